// File: rtl/max_pool_layer.sv
// Streaming non-overlapping POOL_SIZE x POOL_SIZE signed max pooling over a
// raster-order, valid-qualified feature map, all channels in parallel.

module max_pool_lane #(
    parameter int D_WIDTH = 16,
    parameter int NW      = 4,
    parameter int OW      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic                      start_i,
    input  logic                      last_i,
    input  logic [OW-1:0]             oc_i,
    input  logic signed [D_WIDTH-1:0] x_i,
    output logic signed [D_WIDTH-1:0] y_o
);
    logic signed [D_WIDTH-1:0] pm_q [NW];
    logic signed [D_WIDTH-1:0] y_q;
    logic signed [D_WIDTH-1:0] m;

    assign m   = (x_i > pm_q[oc_i]) ? x_i : pm_q[oc_i];
    assign y_o = y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) pm_q[i] <= '0;
            y_q <= '0;
        end else if (en_i) begin
            if (start_i)     pm_q[oc_i] <= x_i;
            else if (last_i) y_q        <= m;
            else             pm_q[oc_i] <= m;
        end
    end
endmodule

module max_pool_layer #(
    parameter int D_WIDTH    = 16,
    parameter int CHANNELS   = 4,
    parameter int IMAGE_SIZE = 8,
    parameter int POOL_SIZE  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_en,
    input  logic [D_WIDTH*CHANNELS-1:0]   input_data,
    output logic [D_WIDTH*CHANNELS-1:0]   output_data,
    output logic                          valid
);
    localparam int NW = IMAGE_SIZE / POOL_SIZE;
    localparam int PW = $clog2(POOL_SIZE);
    localparam int OW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(POOL_SIZE - 1);
    localparam logic [OW-1:0] OC_LAST = OW'(NW - 1);

    if ((IMAGE_SIZE % POOL_SIZE) != 0 || POOL_SIZE < 2) begin : g_bad_param
        $error("max_pool_layer: IMAGE_SIZE must be a multiple of POOL_SIZE and POOL_SIZE >= 2");
    end

    // col is (oc, px); row only matters through py, and because IMAGE_SIZE is
    // a multiple of POOL_SIZE the frame wrap coincides with a py wrap.
    logic [PW-1:0] px_q, px_d, py_q, py_d;
    logic [OW-1:0] oc_q, oc_d;
    logic          valid_q;
    logic          win_start, win_last;

    assign win_start = (px_q == '0) && (py_q == '0);
    assign win_last  = (px_q == P_LAST) && (py_q == P_LAST);

    always_comb begin
        px_d = px_q;
        py_d = py_q;
        oc_d = oc_q;
        if (clk_en) begin
            if (px_q == P_LAST) begin
                px_d = '0;
                if (oc_q == OC_LAST) begin
                    oc_d = '0;
                    py_d = (py_q == P_LAST) ? '0 : py_q + PW'(1);
                end else begin
                    oc_d = oc_q + OW'(1);
                end
            end else begin
                px_d = px_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q    <= '0;
            py_q    <= '0;
            oc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            px_q    <= px_d;
            py_q    <= py_d;
            oc_q    <= oc_d;
            valid_q <= clk_en && win_last;
        end
    end

    assign valid = valid_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        max_pool_lane #(.D_WIDTH(D_WIDTH), .NW(NW), .OW(OW)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (clk_en),
            .start_i (win_start),
            .last_i  (win_last),
            .oc_i    (oc_q),
            .x_i     (input_data[c*D_WIDTH +: D_WIDTH]),
            .y_o     (output_data[c*D_WIDTH +: D_WIDTH])
        );
    end
endmodule

// File: tb/tb_max_pool_layer.sv
// Directed bench for max_pool_layer: a 4x4/2x2 two-channel instance for the
// directed cases and a 6x6/3x3 four-channel instance for the random sweep.

module tb_max_pool_layer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en_a = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] out_a;
    logic        valid_a;

    logic        en_b = 1'b0;
    logic [63:0] in_b = '0;
    logic [63:0] out_b;
    logic        valid_b;

    max_pool_layer #(.D_WIDTH(8), .CHANNELS(2), .IMAGE_SIZE(4), .POOL_SIZE(2)) u_a (
        .clk(clk), .rst_n(rst_n), .clk_en(en_a), .input_data(in_a),
        .output_data(out_a), .valid(valid_a));

    max_pool_layer #(.D_WIDTH(16), .CHANNELS(4), .IMAGE_SIZE(6), .POOL_SIZE(3)) u_b (
        .clk(clk), .rst_n(rst_n), .clk_en(en_b), .input_data(in_b),
        .output_data(out_b), .valid(valid_b));

    int n_chk = 0;
    int n_fail = 0;

    int       n_acc = 0;
    logic     last_en = 1'b0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         qn[$];
    logic       qe[$];
    logic [63:0] qb[$];
    logic [63:0] eb[$];
    logic [7:0]  sv [4];

    always @(posedge clk) begin
        last_en = en_a;
        if (en_a) n_acc = n_acc + 1;
    end

    always @(negedge clk) begin
        if (valid_a) begin
            q0.push_back(out_a[7:0]);
            q1.push_back(out_a[15:8]);
            qn.push_back(n_acc);
            qe.push_back(last_en);
        end
        if (valid_b) qb.push_back(out_b);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<2ms", $time);
        $fatal(1);
    end

    task automatic clear_a();
        q0.delete(); q1.delete(); qn.delete(); qe.delete();
        n_acc = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_a(input logic [7:0] c0, input logic [7:0] c1, input bit stall);
        if (stall) idle($urandom_range(0, 3));
        in_a = {c1, c0};
        en_a = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b0;
    endtask

    // mode 0: ramp, 1: signed window set, 2: constant 42; n limits the sample count
    task automatic frame_a(input int mode, input bit stall, input int n);
        int i, w, k;
        logic [7:0] c0, c1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                i = r * 4 + c;
                if (i < n) begin
                    w = (r / 2) * 2 + (c / 2);
                    k = (r % 2) * 2 + (c % 2);
                    case (mode)
                        0: begin c0 = 8'(i); c1 = 8'(15 - i); end
                        1: begin c0 = sv[(k + w) % 4]; c1 = sv[(k + w + 1) % 4]; end
                        default: begin c0 = 8'd42; c1 = 8'd42; end
                    endcase
                    drive_a(c0, c1, stall);
                end
            end
    endtask

    task automatic check_ramp(input string tag, input bit chk_n);
        logic [7:0] e0 [4];
        logic [7:0] e1 [4];
        int en [4];
        e0[0] = 8'd5;  e0[1] = 8'd7;  e0[2] = 8'd13; e0[3] = 8'd15;
        e1[0] = 8'd15; e1[1] = 8'd13; e1[2] = 8'd7;  e1[3] = 8'd5;
        en[0] = 6; en[1] = 8; en[2] = 14; en[3] = 16;
        n_chk++;
        if (q0.size() !== 4) begin
            n_fail++;
            $display("FAIL %s_count: got %0d strobes, required 4", tag, q0.size());
        end
        for (int i = 0; i < 4; i++) if (i < q0.size()) begin
            n_chk++;
            if (q0[i] !== e0[i] || q1[i] !== e1[i]) begin
                n_fail++;
                $display("FAIL %s_data[%0d]: got ch0=%0d ch1=%0d, required ch0=%0d ch1=%0d",
                         tag, i, q0[i], q1[i], e0[i], e1[i]);
            end
            if (chk_n) begin
                n_chk++;
                if (qn[i] !== en[i] || qe[i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_latency[%0d]: got after sample %0d (en_prev=%0b), required after sample %0d (en_prev=1)",
                             tag, i, qn[i], qe[i], en[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_chk++;
        if (valid_a !== 1'b0 || out_a !== 16'h0 || valid_b !== 1'b0 || out_b !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_state: got va=%0b oa=%h vb=%0b ob=%h, required all zero",
                     valid_a, out_a, valid_b, out_b);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        clear_a();
        frame_a(0, 1'b0, 16);
        idle(3);
        check_ramp("ramp", 1'b1);
    endtask

    task automatic test_signed();
        sv[0] = 8'h80; sv[1] = 8'hFF; sv[2] = 8'h9C; sv[3] = 8'hCE;
        clear_a();
        frame_a(1, 1'b0, 16);
        idle(3);
        n_chk++;
        if (q0.size() !== 4) begin
            n_fail++;
            $display("FAIL signed_count: got %0d strobes, required 4", q0.size());
        end
        for (int i = 0; i < 4; i++) if (i < q0.size()) begin
            n_chk++;
            if (q0[i] !== 8'hFF || q1[i] !== 8'hFF) begin
                n_fail++;
                $display("FAIL signed_data[%0d]: got ch0=%h ch1=%h, required ff ff", i, q0[i], q1[i]);
            end
        end
    endtask

    task automatic test_stalls();
        clear_a();
        frame_a(0, 1'b1, 16);
        idle(3);
        check_ramp("stall", 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        clear_a();
        frame_a(0, 1'b0, 7);
        n_chk++;
        if (out_a !== {8'd15, 8'd5}) begin
            n_fail++;
            $display("FAIL midrst_pre: got %h, required %h", out_a, {8'd15, 8'd5});
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (valid_a !== 1'b0 || out_a !== 16'h0) begin
            n_fail++;
            $display("FAIL midrst_clear: got valid=%0b data=%h, required 0 0000", valid_a, out_a);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        clear_a();
        frame_a(0, 1'b0, 16);
        idle(3);
        check_ramp("midrst", 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] e0 [8];
        logic [7:0] e1 [8];
        e0[0] = 8'd5;  e0[1] = 8'd7;  e0[2] = 8'd13; e0[3] = 8'd15;
        e1[0] = 8'd15; e1[1] = 8'd13; e1[2] = 8'd7;  e1[3] = 8'd5;
        for (int i = 4; i < 8; i++) begin e0[i] = 8'd42; e1[i] = 8'd42; end
        clear_a();
        frame_a(0, 1'b0, 16);
        frame_a(2, 1'b0, 16);
        idle(3);
        n_chk++;
        if (q0.size() !== 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d strobes, required 8", q0.size());
        end
        for (int i = 0; i < 8; i++) if (i < q0.size()) begin
            n_chk++;
            if (q0[i] !== e0[i] || q1[i] !== e1[i]) begin
                n_fail++;
                $display("FAIL b2b_data[%0d]: got ch0=%0d ch1=%0d, required ch0=%0d ch1=%0d",
                         i, q0[i], q1[i], e0[i], e1[i]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [63:0] img [6][6];
        logic [63:0] exp_v;
        logic signed [15:0] mx, v;
        qb.delete(); eb.delete();
        for (int f = 0; f < 100; f++) begin
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 6; c++) begin
                    img[r][c] = {$urandom, $urandom};
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    in_b = img[r][c];
                    en_b = 1'b1;
                    @(posedge clk); #1;
                    en_b = 1'b0;
                end
            for (int wy = 0; wy < 2; wy++)
                for (int wx = 0; wx < 2; wx++) begin
                    for (int ch = 0; ch < 4; ch++) begin
                        mx = 16'sh8000;
                        for (int dy = 0; dy < 3; dy++)
                            for (int dx = 0; dx < 3; dx++) begin
                                v = img[wy*3+dy][wx*3+dx][ch*16 +: 16];
                                if (v > mx) mx = v;
                            end
                        exp_v[ch*16 +: 16] = mx;
                    end
                    eb.push_back(exp_v);
                end
        end
        idle(3);
        n_chk++;
        if (qb.size() !== 400) begin
            n_fail++;
            $display("FAIL sweep_count: got %0d strobes, required 400", qb.size());
        end
        for (int i = 0; i < 400; i++) if (i < qb.size()) begin
            n_chk++;
            if (qb[i] !== eb[i]) begin
                n_fail++;
                $display("FAIL sweep_data[%0d]: got %h, required %h", i, qb[i], eb[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_signed();
        test_stalls();
        test_reset_mid_frame();
        test_back_to_back();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
